// File: rtl/addsub_pipe_pkg.sv
// Shared definitions for the carry-pipelined add/sub unit.
//   mode_e  : operation encodings driven on the 'mode' port
//   chunk_w : width of the slice each pipeline stage adds
package addsub_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_SADD = 2'b10,
        MODE_SSUB = 2'b11
    } mode_e;

    // W must be a multiple of STAGES; each stage handles W/STAGES bits.
    function automatic int chunk_w(input int w, input int stages);
        return w / stages;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CW-bit slice of the pipelined adder (purely combinational).
//   a, b      : operand slices (b already inverted for subtract)
//   cin       : carry into bit 0 of the slice
//   sum       : slice result
//   cout      : carry out of the slice MSB
//   c_msb_in  : carry into the slice MSB (for signed overflow on the top slice)
module addsub_chunk
    import addsub_pipe_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb_in
);

    logic [CW:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum      = full[CW-1:0];
    assign cout     = full[CW];
    // sum MSB = a ^ b ^ carry_in, so the incoming carry falls out by XOR.
    assign c_msb_in = sum[CW-1] ^ a[CW-1] ^ b[CW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Carry-pipelined integer add/subtract with signed saturation and flags.
// Stage k adds bits [k*CW +: CW]; the carry, the not-yet-added operand
// bits and the mode ride along, lower result slices accumulate. The last
// stage applies saturation and registers s plus flags.
//   clk, clrn           : clock, async active-low reset
//   in_valid / in_ready : operand handshake (in_ready = global advance)
//   x, y, mode          : operands, 00 ADD 01 SUB 10 SADD 11 SSUB
//   out_valid/out_ready : result handshake
//   s, carry, ovf, sat, zero, neg : result and status
module addsub_pipe
    import addsub_pipe_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         carry,
    output logic         ovf,
    output logic         sat,
    output logic         zero,
    output logic         neg
);

    localparam int CW = chunk_w(W, STAGES);

    logic              adv;
    logic [STAGES:1]   vld_pipe;   // vld_pipe[k+1] = stage k register holds a beat

    logic [W-1:0]      s_d;
    logic              carry_d, ovf_d, sat_d, fin_ld;
    logic [W-1:0]      s_q;
    logic              carry_q, ovf_q, sat_q, zero_q, neg_q;

    // The whole pipe moves in lockstep; it only freezes when the output is
    // occupied and not being taken.
    assign adv       = !vld_pipe[STAGES] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RIN = W - k*CW;   // operand bits still to be added

        logic [RIN-1:0]        a_all, b_all;
        logic                  cin_c, ld;
        logic [1:0]            md_c;
        logic [CW-1:0]         sum_c;
        logic                  cout_c, cmsb_c;
        logic [(k+1)*CW-1:0]   res_d;

        if (k == 0) begin : g_src
            assign a_all = x;
            assign b_all = y ^ {W{mode[0]}};
            assign cin_c = mode[0];
            assign md_c  = mode;
            assign ld    = adv & in_valid;
            assign res_d = sum_c;
        end else begin : g_src
            assign a_all = g_st[k-1].g_nxt.xr_q;
            assign b_all = g_st[k-1].g_nxt.yr_q;
            assign cin_c = g_st[k-1].g_nxt.c_q;
            assign md_c  = g_st[k-1].g_nxt.md_q;
            assign ld    = adv & vld_pipe[k];
            assign res_d = {sum_c, g_st[k-1].g_nxt.res_q};
        end

        addsub_chunk #(.CW(CW)) u_chunk (
            .a        (a_all[CW-1:0]),
            .b        (b_all[CW-1:0]),
            .cin      (cin_c),
            .sum      (sum_c),
            .cout     (cout_c),
            .c_msb_in (cmsb_c)
        );

        if (k < STAGES-1) begin : g_nxt
            logic [RIN-CW-1:0]     xr_q, yr_q;
            logic [(k+1)*CW-1:0]   res_q;
            logic                  c_q;
            logic [1:0]            md_q;

            // Registers only load for a real beat; bubbles leave them as-is.
            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    xr_q  <= '0;
                    yr_q  <= '0;
                    res_q <= '0;
                    c_q   <= 1'b0;
                    md_q  <= 2'b00;
                end else if (ld) begin
                    xr_q  <= a_all[RIN-1:CW];
                    yr_q  <= b_all[RIN-1:CW];
                    res_q <= res_d;
                    c_q   <= cout_c;
                    md_q  <= md_c;
                end
            end
        end else begin : g_fin
            logic ovf_raw, sat_c;

            assign ovf_raw = cout_c ^ cmsb_c;
            assign sat_c   = md_c[1] & ovf_raw;

            // Clamp toward the sign of x: on overflow x and the effective y
            // share that sign, so it tells which rail was crossed.
            always_comb begin
                s_d = res_d;
                if (sat_c)
                    s_d = a_all[CW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end

            assign carry_d = cout_c;
            assign ovf_d   = ovf_raw;
            assign sat_d   = sat_c;
            assign fin_ld  = ld;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else if (fin_ld) begin
            s_q     <= s_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
            zero_q  <= (s_d == '0);
            neg_q   <= s_d[W-1];
        end
    end

    assign s     = s_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign sat   = sat_q;
    assign zero  = zero_q;
    assign neg   = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (W=32, STAGES=4): accepted beats push a
// reference-model result; a monitor pops and compares on each output beat.
module tb_addsub_pipe;
    import addsub_pipe_pkg::*;

    localparam int W      = 32;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        sa;
        logic        z;
        logic        n;
    } res_t;

    logic         clk = 0;
    logic         clrn = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] x = '0, y = '0;
    logic [1:0]   mode = 2'b00;
    logic         out_valid;
    logic         out_ready = 0;
    logic [W-1:0] s;
    logic         carry, ovf, sat, zero, neg;

    int   n_cmp = 0, n_err = 0, cyc = 0;
    res_t exp_q[$];
    res_t held;
    bit   held_v = 0;

    addsub_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .carry(carry), .ovf(ovf), .sat(sat), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    function automatic res_t dut_res();
        return '{s, carry, ovf, sat, zero, neg};
    endfunction

    // Reference: plain signed/unsigned arithmetic on wide integers.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        res_t r;
        longint sa, sb, sr;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        sr = m[0] ? sa - sb : sa + sb;
        r.c  = m[0] ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
        r.o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.s  = sr[31:0];
        r.sa = m[1] && r.o;
        if (r.sa) r.s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        r.z  = (r.s == 32'h0);
        r.n  = r.s[31];
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Acceptance monitor: every handshaken beat gets its expected result queued.
    initial forever begin
        @(negedge clk);
        if (clrn && in_valid && in_ready) exp_q.push_back(model(x, y, mode));
    end

    // Output monitor: compare on output handshake, check stability while stalled.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!clrn) begin
                held_v = 0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", dut_res(), held);
                end
                held_v = out_valid && !out_ready;
                held   = dut_res();
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got %h, expected no beat", dut_res());
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", dut_res(), e);
                    end
                end
            end
        end
    end

    task automatic send1(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input res_t expv);
        int t0;
        bit got;
        @(posedge clk); #1;
        in_valid = 1; x = a; y = b; mode = m; out_ready = 1;
        @(negedge clk);
        chk({nm, "_accept"}, in_ready, 1);
        t0 = cyc;
        @(posedge clk); #1;
        in_valid = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk({nm, "_latency"}, got ? cyc - t0 : -1, STAGES);
        if (got) chk({nm, "_value"}, dut_res(), expv);
    endtask

    initial begin
        int  sent, guard;
        bit  took;

        // reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", dut_res(), '0);
        #21 clrn = 1;
        #1 chk("rst_in_ready", in_ready, 1);

        // directed cases
        send1("add_ripple16", 32'h0000_FFFF, 32'h0000_0001, MODE_ADD,  '{32'h0001_0000, 0, 0, 0, 0, 0});
        send1("add_ripple32", 32'hFFFF_FFFF, 32'h0000_0001, MODE_ADD,  '{32'h0000_0000, 1, 0, 0, 1, 0});
        send1("sub_borrow",   32'h0000_0005, 32'h0000_0007, MODE_SUB,  '{32'hFFFF_FFFE, 0, 0, 0, 0, 1});
        send1("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, MODE_ADD,  '{32'h8000_0000, 0, 1, 0, 0, 1});
        send1("sadd_sat",     32'h7FFF_FFFF, 32'h0000_0001, MODE_SADD, '{32'h7FFF_FFFF, 0, 1, 1, 0, 0});
        send1("ssub_sat",     32'h8000_0000, 32'h0000_0001, MODE_SSUB, '{32'h8000_0000, 1, 1, 1, 0, 1});
        send1("ssub_plain",   32'h0000_0003, 32'h0000_0001, MODE_SSUB, '{32'h0000_0002, 1, 0, 0, 0, 0});

        // random stream with random in_valid / out_ready
        sent = 0; guard = 0; took = 0;
        while (sent < 16 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (took || !in_valid) begin
                took = 0;
                in_valid = ($urandom_range(0, 2) != 0);
                if (in_valid) begin
                    x = rnd_op(); y = rnd_op(); mode = 2'($urandom_range(0, 3));
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin took = 1; sent++; end
        end
        chk("stream_sent", sent, 16);
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);

        // async reset with beats in flight and the output stalled
        @(posedge clk); #1;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; x = rnd_op(); y = rnd_op(); mode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 0;
        @(posedge clk); #3;
        chk("pre_rst_valid", out_valid, 1);
        clrn = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", dut_res(), '0);
        exp_q.delete();
        @(posedge clk); #3;
        clrn = 1;
        #1 chk("midrst_in_ready", in_ready, 1);
        send1("post_rst", 32'hFFFF_FFFF, 32'h0000_0001, MODE_ADD, '{32'h0000_0000, 1, 0, 0, 1, 0});
        repeat (3) @(posedge clk);
        chk("final_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
